// File: rtl/tetris_grid_pkg.sv
// Shared constants for the Tetris playfield store: cell encoding, clear-engine states and default geometry.
package tetris_grid_pkg;

    localparam int DEF_GRID_W     = 10;
    localparam int DEF_GRID_H     = 20;
    localparam int DEF_CELL_BITS  = 2;
    localparam int DEF_COORD_BITS = 5;
    localparam int DEF_IND_BITS   = 9;

    localparam int CELL_EMPTY = 0;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        DONE
    } clr_state_e;

endpackage

// File: rtl/tetris_grid_mem_row_full_detect.sv
// Combinational full-row test: high when every cell of the row is non-empty.
module row_full_detect
    import tetris_grid_pkg::*;
#(
    parameter int GRID_W    = DEF_GRID_W,
    parameter int CELL_BITS = DEF_CELL_BITS
) (
    input  logic [GRID_W-1:0][CELL_BITS-1:0] row,
    output logic                             full
);

    logic [GRID_W-1:0] occ;

    for (genvar i = 0; i < GRID_W; i++) begin : g_cell
        assign occ[i] = (row[i] != CELL_BITS'(CELL_EMPTY));
    end

    assign full = &occ;

endmodule

// File: rtl/tetris_grid_mem.sv
// Tetris playfield store with one write port, a registered read port and a line-clear engine.
// Optional macro TETRIS_GRID_TOTAL_LINES_EN adds a 16-bit running total of cleared lines.
module tetris_grid_mem
    import tetris_grid_pkg::*;
#(
    parameter int GRID_W     = DEF_GRID_W,
    parameter int GRID_H     = DEF_GRID_H,
    parameter int CELL_BITS  = DEF_CELL_BITS,
    parameter int COORD_BITS = DEF_COORD_BITS,
    parameter int IND_BITS   = DEF_IND_BITS
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [COORD_BITS-1:0]         wr_x,
    input  logic [COORD_BITS-1:0]         wr_y,
    input  logic [CELL_BITS-1:0]          wr_data,
    input  logic [COORD_BITS-1:0]         rd_x,
    input  logic [COORD_BITS-1:0]         rd_y,
    output logic [CELL_BITS-1:0]          rd_data,
    output logic [IND_BITS-1:0]           rd_ind,
    output logic                          rd_oob,
    input  logic                          clear_start,
    output logic                          busy,
    output logic                          clear_done,
`ifdef TETRIS_GRID_TOTAL_LINES_EN
    output logic [15:0]                   total_lines,
`endif
    output logic [$clog2(GRID_H+1)-1:0]   lines_cleared
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int LW = $clog2(GRID_H + 1);

    logic [GRID_H-1:0][GRID_W-1:0][CELL_BITS-1:0] grid;
    clr_state_e    state;
    logic [YW-1:0] r, s;
    logic          row_full;
    logic          rd_in, wr_ok;
    logic [IND_BITS-1:0] lin;

    // Only the row under the scan pointer is ever tested.
    row_full_detect #(.GRID_W(GRID_W), .CELL_BITS(CELL_BITS)) u_full (
        .row  (grid[r]),
        .full (row_full)
    );

    assign rd_in = (rd_x < COORD_BITS'(GRID_W)) && (rd_y < COORD_BITS'(GRID_H));
    assign wr_ok = wr_en && !busy && (wr_x < COORD_BITS'(GRID_W)) && (wr_y < COORD_BITS'(GRID_H));
    assign lin   = IND_BITS'(rd_y) * IND_BITS'(GRID_W) + IND_BITS'(rd_x);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grid          <= '0;
            state         <= IDLE;
            r             <= '0;
            s             <= '0;
            busy          <= 1'b0;
            clear_done    <= 1'b0;
            lines_cleared <= '0;
            rd_data       <= '0;
            rd_ind        <= '0;
            rd_oob        <= 1'b0;
        end else begin
            rd_oob     <= !rd_in;
            rd_data    <= rd_in ? grid[rd_y[YW-1:0]][rd_x[XW-1:0]] : '0;
            rd_ind     <= rd_in ? lin : '0;
            clear_done <= 1'b0;

            if (wr_ok)
                grid[wr_y[YW-1:0]][wr_x[XW-1:0]] <= wr_data;

            case (state)
                IDLE: if (clear_start) begin
                    state         <= SCAN;
                    busy          <= 1'b1;
                    lines_cleared <= '0;
                    r             <= YW'(GRID_H - 1);
                end
                SCAN: if (row_full) begin
                    s     <= r;
                    state <= SHIFT;
                end else if (r == '0) begin
                    state      <= DONE;
                    busy       <= 1'b0;
                    clear_done <= 1'b1;
                end else begin
                    r <= r - YW'(1);
                end
                // r is left alone so the row that just dropped into it is retested.
                SHIFT: if (s == '0) begin
                    grid[0]       <= '0;
                    lines_cleared <= lines_cleared + LW'(1);
                    state         <= SCAN;
                end else begin
                    grid[s] <= grid[s - YW'(1)];
                    s       <= s - YW'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TETRIS_GRID_TOTAL_LINES_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            total_lines <= '0;
        else if (state == DONE)
            total_lines <= total_lines + 16'(lines_cleared);
    end
`endif

endmodule

// File: tb/tb_tetris_grid_mem.sv
// Self-checking bench for tetris_grid_mem against a row-filtering playfield model.
module tb_tetris_grid_mem;

    localparam int W   = 10;
    localparam int H   = 20;
    localparam int CB  = 2;
    localparam int COB = 5;
    localparam int IB  = 9;
    localparam int LB  = $clog2(H + 1);

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           wr_en = 1'b0;
    logic [COB-1:0] wr_x = '0, wr_y = '0;
    logic [CB-1:0]  wr_data = '0;
    logic [COB-1:0] rd_x = '0, rd_y = '0;
    logic [CB-1:0]  rd_data;
    logic [IB-1:0]  rd_ind;
    logic           rd_oob;
    logic           clear_start = 1'b0;
    logic           busy, clear_done;
    logic [LB-1:0]  lines_cleared;
`ifdef TETRIS_GRID_TOTAL_LINES_EN
    logic [15:0]    total_lines;
`endif

    int errors = 0;
    int checks = 0;
    int mdl[H][W];
    int exp_total = 0;

    tetris_grid_mem dut (
        .clock(clock), .reset(reset),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .rd_ind(rd_ind), .rd_oob(rd_oob),
        .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
`ifdef TETRIS_GRID_TOTAL_LINES_EN
        .total_lines(total_lines),
`endif
        .lines_cleared(lines_cleared)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic void model_zero();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                mdl[y][x] = 0;
    endfunction

    // Keep non-full rows in order, stacked at the bottom; zero-fill the top.
    function automatic int model_clear();
        int nxt[H][W];
        int dst = H - 1;
        int full;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                nxt[y][x] = 0;
        for (int y = H - 1; y >= 0; y--) begin
            full = 1;
            for (int x = 0; x < W; x++)
                if (mdl[y][x] == 0) full = 0;
            if (!full) begin
                for (int x = 0; x < W; x++) nxt[dst][x] = mdl[y][x];
                dst--;
            end
        end
        mdl = nxt;
        return dst + 1;
    endfunction

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        model_zero();
        exp_total = 0;
    endtask

    task automatic wr(input int x, input int y, input int d);
        wr_en = 1'b1; wr_x = COB'(x); wr_y = COB'(y); wr_data = CB'(d);
        tick;
        wr_en = 1'b0;
        if (x < W && y < H) mdl[y][x] = d;
    endtask

    task automatic do_read(input int x, input int y, output int d, output int ind, output int oob);
        rd_x = COB'(x); rd_y = COB'(y);
        tick;
        d = int'(rd_data); ind = int'(rd_ind); oob = int'(rd_oob);
    endtask

    task automatic run_pass(output int cyc, output int busy_at_done, output bit seen);
        clear_start = 1'b1;
        tick;
        clear_start = 1'b0;
        cyc = 0; seen = 1'b0; busy_at_done = 1;
        while (!seen && cyc < 2000) begin
            tick;
            cyc++;
            if (clear_done) begin
                seen = 1'b1;
                busy_at_done = int'(busy);
            end
        end
    endtask

    task automatic test_reset;
        int d, ind, oob;
        do_reset();
        do_read(3, 4, d, ind, oob);
        checks++; if (d !== 0)   begin errors++; $display("FAIL reset_rd_data: got %0d expected 0", d); end
        checks++; if (ind !== 43) begin errors++; $display("FAIL reset_rd_ind: got %0d expected 43", ind); end
        checks++; if (oob !== 0) begin errors++; $display("FAIL reset_rd_oob: got %0d expected 0", oob); end
        checks++; if (busy !== 1'b0 || clear_done !== 1'b0 || lines_cleared !== '0) begin
            errors++; $display("FAIL reset_ctrl: got busy=%0b done=%0b lines=%0d expected 0/0/0", busy, clear_done, lines_cleared);
        end
`ifdef TETRIS_GRID_TOTAL_LINES_EN
        checks++; if (total_lines !== 16'd0) begin errors++; $display("FAIL reset_total: got %0d expected 0", total_lines); end
`endif
    endtask

    task automatic test_rw;
        int d, ind, oob, x, y, v, ex, we, wx, wy;
        wr(3, 4, 2);
        do_read(3, 4, d, ind, oob);
        checks++; if (d !== 2) begin errors++; $display("FAIL rw_basic: got %0d expected 2", d); end
        do_read(10, 0, d, ind, oob);
        checks++; if (oob !== 1 || d !== 0 || ind !== 0) begin
            errors++; $display("FAIL rw_oob: got oob=%0d data=%0d ind=%0d expected 1/0/0", oob, d, ind);
        end
        // same-cell read and write on one edge returns the old value
        rd_x = 3; rd_y = 4;
        wr(3, 4, 1);
        checks++; if (rd_data !== 2'd2) begin errors++; $display("FAIL rw_collide_old: got %0d expected 2", rd_data); end
        do_read(3, 4, d, ind, oob);
        checks++; if (d !== 1) begin errors++; $display("FAIL rw_collide_new: got %0d expected 1", d); end
        for (int i = 0; i < 80; i++) begin
            x = $urandom_range(0, 11); y = $urandom_range(0, 21);
            wx = $urandom_range(0, 11); wy = $urandom_range(0, 21);
            v = $urandom_range(0, 3); we = $urandom_range(0, 1);
            ex = (x < W && y < H) ? mdl[y][x] : 0;
            rd_x = COB'(x); rd_y = COB'(y);
            wr_en = we[0]; wr_x = COB'(wx); wr_y = COB'(wy); wr_data = CB'(v);
            tick;
            wr_en = 1'b0;
            if (we != 0 && wx < W && wy < H) mdl[wy][wx] = v;
            checks++;
            if (rd_data !== CB'(ex) || rd_oob !== !(x < W && y < H) || rd_ind !== IB'((x < W && y < H) ? y * W + x : 0)) begin
                errors++;
                $display("FAIL rw_rand(%0d,%0d): got data=%0d oob=%0b ind=%0d expected data=%0d ind=%0d",
                         x, y, rd_data, rd_oob, rd_ind, ex, (x < W && y < H) ? y * W + x : 0);
            end
        end
    endtask

    task automatic test_clear_one;
        int cyc, bd, d, ind, oob, n;
        bit seen;
        do_reset();
        for (int x = 0; x < W; x++) wr(x, 19, 1);
        wr(0, 18, 3);
        run_pass(cyc, bd, seen);
        n = model_clear();
        exp_total += n;
        checks++; if (!seen) begin errors++; $display("FAIL clr1_timeout: got no clear_done expected pulse"); end
        checks++; if (bd !== 0) begin errors++; $display("FAIL clr1_busy_at_done: got %0d expected 0", bd); end
        checks++; if (lines_cleared !== LB'(1) || n != 1) begin
            errors++; $display("FAIL clr1_lines: got %0d expected 1 (model %0d)", lines_cleared, n);
        end
        tick;
        checks++; if (clear_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL clr1_pulse: got done=%0b busy=%0b expected 0/0", clear_done, busy);
        end
        do_read(0, 19, d, ind, oob);
        checks++; if (d !== 3) begin errors++; $display("FAIL clr1_drop: got %0d expected 3", d); end
        for (int x = 0; x < W; x++) begin
            do_read(x, 18, d, ind, oob);
            checks++; if (d !== 0) begin errors++; $display("FAIL clr1_row18[%0d]: got %0d expected 0", x, d); end
        end
    endtask

    task automatic test_clear_two;
        int cyc, bd, d, ind, oob, n;
        bit seen;
        for (int x = 0; x < W; x++) begin
            wr(x, 18, $urandom_range(1, 3));
            wr(x, 19, $urandom_range(1, 3));
        end
        run_pass(cyc, bd, seen);
        n = model_clear();
        exp_total += n;
        checks++; if (!seen || lines_cleared !== LB'(2) || n != 2) begin
            errors++; $display("FAIL clr2_lines: got %0d seen=%0b expected 2 (model %0d)", lines_cleared, seen, n);
        end
        for (int y = 18; y < H; y++)
            for (int x = 0; x < W; x++) begin
                do_read(x, y, d, ind, oob);
                checks++; if (d !== 0) begin errors++; $display("FAIL clr2_cell(%0d,%0d): got %0d expected 0", x, y, d); end
            end
`ifdef TETRIS_GRID_TOTAL_LINES_EN
        checks++; if (total_lines !== 16'd3) begin errors++; $display("FAIL clr2_total: got %0d expected 3", total_lines); end
`endif
    endtask

    task automatic test_busy;
        int cyc, d, ind, oob, n, extra;
        do_reset();
        for (int x = 0; x < W; x++) wr(x, 19, 1);
        wr(0, 0, 2);
        clear_start = 1'b1;
        tick;
        clear_start = 1'b0;
        tick;
        tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_high: got %0b expected 1", busy); end
        wr_en = 1'b1; wr_x = 0; wr_y = 0; wr_data = 2'd3; clear_start = 1'b1;
        tick;
        wr_en = 1'b0; clear_start = 1'b0;
        cyc = 0;
        while (clear_done !== 1'b1 && cyc < 2000) begin tick; cyc++; end
        n = model_clear();
        exp_total += n;
        checks++; if (clear_done !== 1'b1 || lines_cleared !== LB'(n)) begin
            errors++; $display("FAIL busy_pass: got done=%0b lines=%0d expected 1/%0d", clear_done, lines_cleared, n);
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (busy || clear_done) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL busy_second_pass: got %0d active cycles expected 0", extra); end
        do_read(0, 0, d, ind, oob);
        checks++; if (d !== mdl[0][0]) begin errors++; $display("FAIL busy_wr_ignored(0,0): got %0d expected %0d", d, mdl[0][0]); end
        do_read(0, 1, d, ind, oob);
        checks++; if (d !== mdl[1][0]) begin errors++; $display("FAIL busy_shifted(0,1): got %0d expected %0d", d, mdl[1][0]); end
    endtask

    task automatic test_random_clear;
        int cyc, bd, d, ind, oob, n, full, bad;
        bit seen;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            for (int y = 0; y < H; y++) begin
                full = ($urandom_range(0, 2) == 0);
                for (int x = 0; x < W; x++)
                    wr(x, y, full ? $urandom_range(1, 3) : $urandom_range(0, 3));
            end
            run_pass(cyc, bd, seen);
            n = model_clear();
            checks++; if (!seen || lines_cleared !== LB'(n)) begin
                errors++; $display("FAIL rnd_lines[%0d]: got %0d seen=%0b expected %0d", t, lines_cleared, seen, n);
            end
            bad = 0;
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    do_read(x, y, d, ind, oob);
                    if (d !== mdl[y][x]) begin
                        bad++;
                        if (bad < 4) $display("FAIL rnd_cell[%0d](%0d,%0d): got %0d expected %0d", t, x, y, d, mdl[y][x]);
                    end
                end
            checks++; if (bad != 0) errors++;
`ifdef TETRIS_GRID_TOTAL_LINES_EN
            tick;
            checks++; if (total_lines !== 16'(n)) begin errors++; $display("FAIL rnd_total[%0d]: got %0d expected %0d", t, total_lines, n); end
`endif
        end
    endtask

    task automatic test_reset_mid;
        int cyc, bd, d, ind, oob, bad;
        bit seen;
        do_reset();
        for (int x = 0; x < W; x++) begin
            wr(x, 19, 2);
            wr(x, 18, 1);
        end
        wr(5, 3, 2);
        clear_start = 1'b1;
        tick;
        clear_start = 1'b0;
        tick; tick; tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %0b expected 1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || clear_done !== 1'b0 || lines_cleared !== '0) begin
            errors++; $display("FAIL mid_async: got busy=%0b done=%0b lines=%0d expected 0/0/0", busy, clear_done, lines_cleared);
        end
        tick;
        reset = 1'b0;
        model_zero();
        exp_total = 0;
        bad = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                do_read(x, y, d, ind, oob);
                if (d !== 0) begin
                    bad++;
                    if (bad < 4) $display("FAIL mid_grid(%0d,%0d): got %0d expected 0", x, y, d);
                end
            end
        checks++; if (bad != 0) errors++;
`ifdef TETRIS_GRID_TOTAL_LINES_EN
        checks++; if (total_lines !== 16'd0) begin errors++; $display("FAIL mid_total: got %0d expected 0", total_lines); end
`endif
        // FSM must be idle: an empty-grid pass takes exactly one scan per row
        run_pass(cyc, bd, seen);
        checks++; if (!seen || cyc != H || lines_cleared !== '0) begin
            errors++; $display("FAIL empty_pass: got cycles=%0d lines=%0d seen=%0b expected %0d/0/1", cyc, lines_cleared, seen, H);
        end
    endtask

    initial begin
        test_reset();
        test_rw();
        test_clear_one();
        test_clear_two();
        test_busy();
        test_random_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
